// File: rtl/shared_mult_sequencer_if.sv
// Operand-load / start / busy / done handshake bundle for the shared-multiplier sequencer.
// The master side drives loads and start; the slave side returns the registered result.
interface shared_mult_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic               ld_ab;
  logic               ld_cd;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               overflow;

  modport master (
    output ld_ab, ld_cd, a_in, b_in, start,
    input  busy, done, result, overflow
  );

  modport slave (
    input  ld_ab, ld_cd, a_in, b_in, start,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/shared_mult_sequencer.sv
// Computes A*B + C*D by running one shift-add multiplier twice, then summing the two
// products with a carry-out overflow flag. Latency from start to done is fixed at 2*WIDTH+1.
module shared_mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  shared_mult_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL_AB, MUL_CD, SUM} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [2*WIDTH-1:0] p_q, p_d, p1_q, p1_d, m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [2*WIDTH-1:0] p_step;
  logic [2*WIDTH:0]   sum;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    p_d        = p_q;
    p1_d       = p1_q;
    m_d        = m_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    p_step     = q_q[0] ? (p_q + m_q) : p_q;
    sum        = {1'b0, p1_q} + {1'b0, p_q};

    case (state_q)
      IDLE: begin
        // Start latches the pre-edge operands, so a same-cycle load only affects later runs.
        if (bus.ld_ab) begin
          a_d = bus.a_in;
          b_d = bus.b_in;
        end else if (bus.ld_cd) begin
          c_d = bus.a_in;
          d_d = bus.b_in;
        end
        if (bus.start) begin
          state_d = MUL_AB;
          m_d     = {{WIDTH{1'b0}}, a_q};
          q_d     = b_q;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      MUL_AB, MUL_CD: begin
        p_d   = p_step;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          if (state_q == MUL_AB) begin
            // First product parks in P1 while the engine is reloaded with C and D.
            p1_d    = p_step;
            m_d     = {{WIDTH{1'b0}}, c_q};
            q_d     = d_q;
            p_d     = '0;
            cnt_d   = '0;
            state_d = MUL_CD;
          end else begin
            state_d = SUM;
          end
        end
      end
      SUM: begin
        {overflow_d, result_d} = sum;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      p_q        <= '0;
      p1_q       <= '0;
      m_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      p_q        <= p_d;
      p1_q       <= p1_d;
      m_q        <= m_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_shared_mult_sequencer.sv
// Directed bench for shared_mult_sequencer: hand-computed A*B+C*D results, latency,
// ignored inputs while busy, mid-run reset, load/start collisions and back-to-back runs.
module tb_shared_mult_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   lat;
  int   busy_cnt;
  int   done_cnt;

  shared_mult_sequencer_if #(.WIDTH(8)) bus ();

  shared_mult_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, lets the DUT sample them, then returns everything to idle.
  task automatic applyStimulus(input logic lab, input logic lcd, input logic [7:0] a,
                               input logic [7:0] b, input logic st);
    bus.ld_ab = lab;
    bus.ld_cd = lcd;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = st;
    tick();
    bus.ld_ab = 1'b0;
    bus.ld_cd = 1'b0;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded), tallying busy cycles along the way.
  task automatic waitDone(output int edges, output int busy_seen);
    edges     = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) busy_seen++;
      if (bus.done === 1'b1) break;
      tick();
      edges++;
    end
  endtask

  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.ld_ab = 1'b0;
    bus.ld_cd = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.start = 1'b0;
    tick();

    doReset();
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_a", 32'(dut.a_q), 32'd0);

    applyStimulus(1'b1, 1'b0, 8'd3, 8'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd5, 8'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("basic_latency", 32'(lat), 32'd17);
    checkOutput("basic_busy_cycles", 32'(busy_cnt), 32'd17);
    checkOutput("basic_result", 32'(bus.result), 32'd42);
    checkOutput("basic_overflow", 32'(bus.overflow), 32'd0);
    tick();
    checkOutput("basic_done_width", 32'(bus.done), 32'd0);

    applyStimulus(1'b1, 1'b0, 8'd255, 8'd255, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd255, 8'd255, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("ovf_latency", 32'(lat), 32'd17);
    checkOutput("ovf_result", 32'(bus.result), 32'hFC02);
    checkOutput("ovf_overflow", 32'(bus.overflow), 32'd1);

    applyStimulus(1'b1, 1'b0, 8'd3, 8'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd5, 8'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 8'd9, 8'd9, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd9, 8'd9, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("busy_ign_done_seen", 32'(bus.done), 32'd1);
    checkOutput("busy_ign_result", 32'(bus.result), 32'd42);
    checkOutput("busy_ign_overflow", 32'(bus.overflow), 32'd0);
    countDone(25, done_cnt);
    checkOutput("busy_ign_single_done", 32'(done_cnt), 32'd0);
    checkOutput("busy_ign_idle", 32'(bus.busy), 32'd0);
    checkOutput("busy_ign_a", 32'(dut.a_q), 32'd3);
    checkOutput("busy_ign_b", 32'(dut.b_q), 32'd4);
    checkOutput("busy_ign_c", 32'(dut.c_q), 32'd5);
    checkOutput("busy_ign_d", 32'(dut.d_q), 32'd6);

    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_busy_before", 32'(bus.busy), 32'd1);
    doReset();
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_result", 32'(bus.result), 32'd0);
    countDone(40, done_cnt);
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    checkOutput("midrst_result_hold", 32'(bus.result), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd2, 8'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd4, 8'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("midrst_rerun_latency", 32'(lat), 32'd17);
    checkOutput("midrst_rerun_result", 32'(bus.result), 32'd26);

    doReset();
    applyStimulus(1'b1, 1'b1, 8'd7, 8'd8, 1'b0);
    checkOutput("both_ld_a", 32'(dut.a_q), 32'd7);
    checkOutput("both_ld_b", 32'(dut.b_q), 32'd8);
    checkOutput("both_ld_c", 32'(dut.c_q), 32'd0);
    checkOutput("both_ld_d", 32'(dut.d_q), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd10, 8'd10, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("ld_start_latency", 32'(lat), 32'd17);
    checkOutput("ld_start_result", 32'(bus.result), 32'd56);
    checkOutput("ld_start_a", 32'(dut.a_q), 32'd10);
    checkOutput("ld_start_b", 32'(dut.b_q), 32'd10);

    applyStimulus(1'b1, 1'b0, 8'd0, 8'd200, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd12, 8'd11, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    waitDone(lat, busy_cnt);
    checkOutput("zero_latency", 32'(lat), 32'd17);
    checkOutput("zero_result", 32'(bus.result), 32'd132);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    waitDone(lat, busy_cnt);
    checkOutput("b2b_gap", 32'(lat + 1), 32'd18);
    checkOutput("b2b_result", 32'(bus.result), 32'd132);
    checkOutput("b2b_overflow", 32'(bus.overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_mult_sequencer.md
# shared_mult_sequencer

Sequencer that computes S = A*B + C*D on a single shared iterative shift-add multiplier. It replaces two parallel multipliers in the switch-driven multiply-accumulate datapath. Operands are loaded in pairs from the switch bus. A start/busy/done handshake brings the 7-segment display path a registered result plus an overflow flag.

## Interface
Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits; result is 2*WIDTH bits plus overflow.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- ld_ab  in  1  load a_in→A, b_in→B (IDLE only).
- ld_cd  in  1  load a_in→C, b_in→D (IDLE only).
- a_in  in  WIDTH  first operand of pair.
- b_in  in  WIDTH  second operand of pair.
- start  in  1  begin computation (IDLE only).
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when result is written.
- result  out  2*WIDTH  registered (A*B + C*D) mod 2^(2*WIDTH).
- overflow  out  1  carry out of the final 2*WIDTH-bit add.

## Operation
- Registers: A, B, C, D (WIDTH each); P1 (2W product store); shift-add engine with P (2W accumulator), M (2W multiplicand), Q (W multiplier), cnt (ceil(log2 W) bits).
- FSM states: IDLE, MUL_AB, MUL_CD, SUM.
- IDLE:
  - ld_ab loads A/B. Otherwise ld_cd loads C/D. If both are high, only A/B are loaded.
  - start → MUL_AB. Set M={0,A}, Q=B, P=0, cnt=0, busy=1.
  - Operand values used are the pre-edge register values. A load in the same cycle as start still updates the registers but does not affect this run.
- Iteration (MUL_AB, MUL_CD), every cycle:
  - if Q[0], P += M.
  - M <<= 1; Q >>= 1; cnt++.
- MUL_AB exit, on the iteration with cnt==W-1:
  - P1 = final P.
  - Reload M={0,C}, Q=D, P=0, cnt=0.
  - Go to MUL_CD.
- MUL_CD exit, on the iteration with cnt==W-1: keep the final P as P2, go to SUM.
- SUM (one cycle):
  - {overflow, result} = P1 + P2, a (2W+1)-bit sum.
  - done=1, busy=0, go to IDLE.
- Ignored while busy: start, ld_ab and ld_cd. Operand registers are stable for the whole run.
- result and overflow hold their values until the next SUM or reset.
- No early termination on zero operands; latency is fixed.

## Timing
- Call the edge that samples start in IDLE edge 0.
- MUL_AB iterations run on edges 1..W; MUL_CD iterations run on edges W+1..2W.
- SUM writes on edge 2W+1:
  - done is high for exactly the cycle after edge 2W+1.
  - busy is high for cycles after edges 0..2W, i.e. 2W+1 cycles.
  - For W=8: done follows start by 17 edges.
- Back-to-back: start may be asserted in the same cycle done is high, since the FSM is in IDLE. The new run begins on that edge, so one start every 2W+2 cycles is sustainable.
- Reset values, effective on the edge reset is sampled high:
  - state=IDLE; busy=0, done=0, result=0, overflow=0.
  - A=B=C=D=0; P, P1, M, Q, cnt = 0.
- Reset dominates start, loads and any FSM transition.
- Reset mid-run aborts the run. No done pulse follows, and result stays 0.
- done is a registered output, never combinational from start.

## Test plan
- **Basic result:** reset; ld_ab with a_in=3, b_in=4; ld_cd with a_in=5, b_in=6; start → busy for 17 cycles, done pulse 17 edges after start, result=0x002A (42), overflow=0.
- **Overflow:** A=B=C=D=255, start → result=0xFC02 (64514), overflow=1 (true sum 130050).
- **Ignored inputs while busy:** mid-run, assert start, ld_ab (a_in=9, b_in=9) and ld_cd → same result as the undisturbed run (42). A/B still read 3/4 afterwards, and exactly one done pulse.
- **Reset mid-run:** assert reset on edge 5 of the run → busy=0, done stays 0 for 40 cycles, result=0. A subsequent load of 2,3,4,5 and start gives result=26.
- **Simultaneous load and start:**
  - ld_ab and ld_cd high together (a_in=7, b_in=8) → only A/B become 7/8; C/D unchanged.
  - ld_ab (a_in=10, b_in=10) in the same cycle as start, with old A/B=7/8 and C/D=0/0 → result=56; A/B=10/10 afterwards.
- **Zero operand and back-to-back:**
  - A=0, B=200, C=12, D=11 → result=132.
  - Start again in the done cycle → second done exactly 18 cycles after the first, with the same result.
